// File: rtl/rename_freelist_if.sv
// Rename free-list bundle: allocation, release and commit signals between
// the rename/commit pipeline (master) and the free list (slave).
interface rename_freelist_if #(
    parameter int PRF_NUM = 64,
    parameter int ARF_NUM = 32
);
    localparam int DEPTH = PRF_NUM - ARF_NUM;
    localparam int PRF_W = $clog2(PRF_NUM);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             pause;
    logic             alloc_req0;
    logic             alloc_req1;
    logic [PRF_W-1:0] alloc_prf0;
    logic [PRF_W-1:0] alloc_prf1;
    logic             alloc_ok;
    logic             pause_req;
    logic             rel_valid0;
    logic             rel_valid1;
    logic [PRF_W-1:0] rel_prf0;
    logic [PRF_W-1:0] rel_prf1;
    logic             cmt_alloc0;
    logic             cmt_alloc1;
    logic [CNT_W-1:0] free_count;
    logic             overflow_err;

    modport master (
        output flush, pause, alloc_req0, alloc_req1,
        output rel_valid0, rel_valid1, rel_prf0, rel_prf1,
        output cmt_alloc0, cmt_alloc1,
        input  alloc_prf0, alloc_prf1, alloc_ok, pause_req,
        input  free_count, overflow_err
    );

    modport slave (
        input  flush, pause, alloc_req0, alloc_req1,
        input  rel_valid0, rel_valid1, rel_prf0, rel_prf1,
        input  cmt_alloc0, cmt_alloc1,
        output alloc_prf0, alloc_prf1, alloc_ok, pause_req,
        output free_count, overflow_err
    );
endinterface

// File: rtl/rename_freelist.sv
// Circular free list of physical registers with a speculative head for rename,
// a committed head for flush recovery and a tail fed by commit-time releases.
module rename_freelist #(
    parameter int PRF_NUM = 64,
    parameter int ARF_NUM = 32
) (
    input  logic             clk,
    input  logic             rst,
    rename_freelist_if.slave io_bus
);
    localparam int DEPTH = PRF_NUM - ARF_NUM;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int PRF_W = $clog2(PRF_NUM);

    logic [PRF_W-1:0] r_entry [DEPTH];
    logic [PTR_W-1:0] r_spec_head;
    logic [PTR_W-1:0] r_cmt_head;
    logic [PTR_W-1:0] r_tail;
    logic             r_overflow;

    logic [PTR_W-1:0] w_free_count;
    logic [PTR_W-1:0] w_room;
    logic [PTR_W-1:0] w_req_n;
    logic [PTR_W-1:0] w_cmt_n;
    logic [PTR_W-1:0] w_rel_n;
    logic [IDX_W-1:0] w_alloc_idx1;
    logic [IDX_W-1:0] w_rel_idx1;
    logic             w_alloc_ok;
    logic             w_alloc_fire;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_drop;

    // Pointers carry a wrap bit, so tail - spec_head spans the full 0..DEPTH range.
    assign w_free_count = r_tail - r_spec_head;
    assign w_room       = PTR_W'(DEPTH) - w_free_count;
    assign w_req_n      = PTR_W'(io_bus.alloc_req0) + PTR_W'(io_bus.alloc_req1);
    assign w_cmt_n      = PTR_W'(io_bus.cmt_alloc0) + PTR_W'(io_bus.cmt_alloc1);

    assign w_alloc_ok   = (w_free_count >= w_req_n);
    assign w_alloc_fire = w_alloc_ok && !io_bus.pause && !io_bus.flush;
    assign w_alloc_idx1 = r_spec_head[IDX_W-1:0] + IDX_W'(io_bus.alloc_req0);

    // Slot 0 claims room first; slot 1 only fits if space remains after it.
    assign w_acc0     = io_bus.rel_valid0 && (w_room != '0);
    assign w_acc1     = io_bus.rel_valid1 && (w_room > PTR_W'(w_acc0));
    assign w_rel_n    = PTR_W'(w_acc0) + PTR_W'(w_acc1);
    assign w_rel_idx1 = r_tail[IDX_W-1:0] + IDX_W'(w_acc0);
    assign w_drop     = (io_bus.rel_valid0 && !w_acc0) || (io_bus.rel_valid1 && !w_acc1);

    assign io_bus.alloc_prf0   = r_entry[r_spec_head[IDX_W-1:0]];
    assign io_bus.alloc_prf1   = r_entry[w_alloc_idx1];
    assign io_bus.alloc_ok     = w_alloc_ok;
    assign io_bus.pause_req    = !w_alloc_ok;
    assign io_bus.free_count   = w_free_count;
    assign io_bus.overflow_err = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= PRF_W'(ARF_NUM + i);
            end
            r_spec_head <= '0;
            r_cmt_head  <= '0;
            r_tail      <= PTR_W'(DEPTH);
            r_overflow  <= 1'b0;
        end else begin
            if (w_acc0) begin
                r_entry[r_tail[IDX_W-1:0]] <= io_bus.rel_prf0;
            end
            if (w_acc1) begin
                r_entry[w_rel_idx1] <= io_bus.rel_prf1;
            end
            r_tail     <= r_tail + w_rel_n;
            r_cmt_head <= r_cmt_head + w_cmt_n;
            // Flush rewinds to the committed head including this cycle's retirements.
            if (io_bus.flush) begin
                r_spec_head <= r_cmt_head + w_cmt_n;
            end else if (w_alloc_fire) begin
                r_spec_head <= r_spec_head + w_req_n;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rename_freelist.sv
// Randomized and directed bench for rename_freelist against a queue-based model
// of free IDs and allocated-but-uncommitted IDs.
module tb_rename_freelist;
    localparam int PRF_NUM = 64;
    localparam int ARF_NUM = 32;
    localparam int DEPTH   = PRF_NUM - ARF_NUM;

    logic clk;
    logic rst;
    rename_freelist_if #(.PRF_NUM(PRF_NUM), .ARF_NUM(ARF_NUM)) ifc ();

    rename_freelist #(.PRF_NUM(PRF_NUM), .ARF_NUM(ARF_NUM)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    int freeq[$];
    int inflight[$];
    bit m_ovf;

    int m_fc, m_nreq, m_idx;
    int d_nf, d_ni, d_cm, d_room, d_hi;

    task automatic check(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        freeq.delete();
        inflight.delete();
        for (int i = 0; i < DEPTH; i++) freeq.push_back(ARF_NUM + i);
        m_ovf = 1'b0;
    endtask

    // Apply one clock edge's worth of the free-list rules to the queues.
    task automatic model_update();
        int fc, nreq, pend, cm;
        int relq[$];
        if (!rst) begin
            model_reset();
            return;
        end
        fc   = freeq.size();
        nreq = int'(ifc.alloc_req0) + int'(ifc.alloc_req1);
        cm   = int'(ifc.cmt_alloc0) + int'(ifc.cmt_alloc1);
        pend = 0;
        if (ifc.rel_valid0) begin
            if (fc + pend + 1 <= DEPTH) begin relq.push_back(int'(ifc.rel_prf0)); pend++; end
            else m_ovf = 1'b1;
        end
        if (ifc.rel_valid1) begin
            if (fc + pend + 1 <= DEPTH) begin relq.push_back(int'(ifc.rel_prf1)); pend++; end
            else m_ovf = 1'b1;
        end
        if (fc >= nreq && !ifc.pause && !ifc.flush)
            for (int i = 0; i < nreq; i++) inflight.push_back(freeq.pop_front());
        for (int i = 0; i < cm; i++)
            if (inflight.size() > 0) void'(inflight.pop_front());
        if (ifc.flush) begin
            for (int i = inflight.size() - 1; i >= 0; i--) freeq.push_front(inflight[i]);
            inflight.delete();
        end
        foreach (relq[i]) freeq.push_back(relq[i]);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        ifc.flush = 0; ifc.pause = 0; ifc.alloc_req0 = 0; ifc.alloc_req1 = 0;
        ifc.rel_valid0 = 0; ifc.rel_valid1 = 0; ifc.rel_prf0 = '0; ifc.rel_prf1 = '0;
        ifc.cmt_alloc0 = 0; ifc.cmt_alloc1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // Every cycle: outputs must match what the model's queues imply.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                m_fc   = freeq.size();
                m_nreq = int'(ifc.alloc_req0) + int'(ifc.alloc_req1);
                check("free_count", int'(ifc.free_count), m_fc);
                check("alloc_ok", int'(ifc.alloc_ok), int'(m_fc >= m_nreq));
                check("pause_req", int'(ifc.pause_req), int'(m_fc < m_nreq));
                check("overflow_err", int'(ifc.overflow_err), int'(m_ovf));
                if (m_fc > 0) check("alloc_prf0", int'(ifc.alloc_prf0), freeq[0]);
                m_idx = int'(ifc.alloc_req0);
                if (m_fc > m_idx) check("alloc_prf1", int'(ifc.alloc_prf1), freeq[m_idx]);
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b1;
        chk_en = 1'b1;

        // Post-reset outputs
        @(negedge clk);
        check("rst_free_count", int'(ifc.free_count), 32);
        check("rst_alloc_ok", int'(ifc.alloc_ok), 1);
        check("rst_pause_req", int'(ifc.pause_req), 0);
        check("rst_prf0", int'(ifc.alloc_prf0), 32);
        check("rst_prf1_req0lo", int'(ifc.alloc_prf1), 32);
        check("rst_overflow", int'(ifc.overflow_err), 0);
        #1 ifc.alloc_req0 = 1;
        #1 check("rst_prf1_req0hi", int'(ifc.alloc_prf1), 33);
        ifc.alloc_req0 = 0;
        step();

        // Drain the whole list in pairs
        for (int k = 0; k < 16; k++) begin
            ifc.alloc_req0 = 1; ifc.alloc_req1 = 1;
            @(negedge clk);
            check("drain_prf0", int'(ifc.alloc_prf0), 32 + 2 * k);
            check("drain_prf1", int'(ifc.alloc_prf1), 33 + 2 * k);
            step();
        end
        @(negedge clk);
        check("empty_free_count", int'(ifc.free_count), 0);
        check("empty_alloc_ok", int'(ifc.alloc_ok), 0);
        check("empty_pause_req", int'(ifc.pause_req), 1);
        step();
        idle_inputs();
        ifc.cmt_alloc0 = 1; ifc.cmt_alloc1 = 1;
        for (int k = 0; k < 16; k++) step();
        idle_inputs();

        // Dual release into an empty list, then partial-allocation refusal
        ifc.rel_valid0 = 1; ifc.rel_prf0 = 6'd5;
        ifc.rel_valid1 = 1; ifc.rel_prf1 = 6'd9;
        step();
        idle_inputs();
        ifc.alloc_req0 = 1;
        @(negedge clk);
        check("rel2_free_count", int'(ifc.free_count), 2);
        check("rel2_prf0", int'(ifc.alloc_prf0), 5);
        check("rel2_prf1", int'(ifc.alloc_prf1), 9);
        step();
        ifc.alloc_req0 = 1; ifc.alloc_req1 = 1;
        @(negedge clk);
        check("fc1_pair_free_count", int'(ifc.free_count), 1);
        check("fc1_pair_alloc_ok", int'(ifc.alloc_ok), 0);
        check("fc1_pair_pause_req", int'(ifc.pause_req), 1);
        step();
        ifc.alloc_req0 = 0; ifc.alloc_req1 = 1;
        @(negedge clk);
        check("fc1_hold_free_count", int'(ifc.free_count), 1);
        check("fc1_req1_prf1", int'(ifc.alloc_prf1), 9);
        check("fc1_req1_alloc_ok", int'(ifc.alloc_ok), 1);
        step();
        idle_inputs();
        @(negedge clk);
        check("fc1_after_free_count", int'(ifc.free_count), 0);
        step();
        ifc.cmt_alloc0 = 1; ifc.cmt_alloc1 = 1;
        step();
        idle_inputs();

        // Allocate 6, commit 2, flush with one more commit
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ifc.alloc_req0 = 1; ifc.alloc_req1 = 1;
            step();
        end
        idle_inputs();
        ifc.cmt_alloc0 = 1; ifc.cmt_alloc1 = 1;
        step();
        idle_inputs();
        ifc.flush = 1; ifc.cmt_alloc0 = 1;
        step();
        idle_inputs();
        @(negedge clk);
        check("flush_free_count", int'(ifc.free_count), 29);
        check("flush_prf0", int'(ifc.alloc_prf0), 35);
        step();

        // Release into a full list
        do_reset();
        ifc.rel_valid0 = 1; ifc.rel_prf0 = 6'd7;
        step();
        idle_inputs();
        @(negedge clk);
        check("ovf_free_count", int'(ifc.free_count), 32);
        check("ovf_set", int'(ifc.overflow_err), 1);
        check("ovf_entry_kept", int'(ifc.alloc_prf0), 32);
        step();
        step();
        @(negedge clk);
        check("ovf_sticky", int'(ifc.overflow_err), 1);
        step();
        do_reset();
        @(negedge clk);
        check("ovf_cleared", int'(ifc.overflow_err), 0);
        step();

        // Pause: no allocation, release still lands
        ifc.alloc_req0 = 1; ifc.alloc_req1 = 1;
        step();
        idle_inputs();
        ifc.cmt_alloc0 = 1; ifc.cmt_alloc1 = 1;
        step();
        idle_inputs();
        ifc.pause = 1; ifc.alloc_req0 = 1; ifc.rel_valid0 = 1; ifc.rel_prf0 = 6'd11;
        @(negedge clk);
        check("pause_before_fc", int'(ifc.free_count), 30);
        step();
        idle_inputs();
        @(negedge clk);
        check("pause_after_fc", int'(ifc.free_count), 31);
        check("pause_prf0_held", int'(ifc.alloc_prf0), 34);
        step();

        // Randomized traffic, releases bounded by physical occupancy
        for (int c = 0; c < 3000; c++) begin
            d_nf = freeq.size();
            d_ni = inflight.size();
            d_hi = ((c / 150) % 2 == 0) ? 80 : 15;
            ifc.alloc_req0 = ($urandom_range(0, 99) < 60);
            ifc.alloc_req1 = ($urandom_range(0, 99) < 60);
            ifc.pause      = ($urandom_range(0, 99) < 10);
            ifc.flush      = ($urandom_range(0, 99) < 4);
            ifc.cmt_alloc0 = (d_ni >= 1) && ($urandom_range(0, 99) < 70);
            ifc.cmt_alloc1 = (d_ni >= (ifc.cmt_alloc0 ? 2 : 1)) && ($urandom_range(0, 99) < 60);
            d_cm   = int'(ifc.cmt_alloc0) + int'(ifc.cmt_alloc1);
            d_room = DEPTH - d_nf - d_ni + d_cm;
            ifc.rel_valid0 = (d_room >= 1) && ($urandom_range(0, 99) < d_hi);
            ifc.rel_valid1 = (d_room >= (ifc.rel_valid0 ? 2 : 1)) && ($urandom_range(0, 99) < d_hi);
            ifc.rel_prf0   = 6'($urandom_range(0, 63));
            ifc.rel_prf1   = 6'($urandom_range(0, 63));
            rst = !($urandom_range(0, 999) < 2);
            step();
        end
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
